reg_write_demux8_16: RTL and testbench

//  Write side of the 8-entry x 16-bit register bank: steers one 16-bit writeback word into one of eight

---
 rtl/reg_write_demux8_16_pkg.sv | 13 +
 rtl/reg_write_demux8_16_dec3_8.sv | 17 +
 rtl/reg_write_demux8_16.sv | 99 +++++++++
 tb/tb_reg_write_demux8_16.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_demux8_16_pkg.sv
// Shared constants and commit-buffer state encoding for the 8 x 16-bit register bank write side.
package reg_write_demux8_16_pkg;

    localparam int unsigned REG_WIDTH = 16;
    localparam int unsigned REG_NUM   = 8;
    localparam int unsigned REG_SEL_W = 3;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/reg_write_demux8_16_dec3_8.sv
// 3-bit index plus enable to 8-bit one-hot register write enables.
module dec3_8
    import reg_write_demux8_16_pkg::*;
(
    input  logic                 i_en,
    input  logic [REG_SEL_W-1:0] i_sel,
    output logic [REG_NUM-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_demux8_16.sv
// Write side of the 8 x 16-bit register bank: valid/ready into a one-entry commit buffer, then commit.
// Define REGFILE_BYPASS_EN to forward the pending buffered word onto regs_flat while it awaits commit.
module reg_write_demux8_16
    import reg_write_demux8_16_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH,
    parameter int unsigned NREG  = REG_NUM,
    parameter int unsigned SEL_W = REG_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,
    input  logic                  hold,
    output logic [NREG*WIDTH-1:0] regs_flat,
    output logic                  pend_valid,
    output logic [7:0]            wr_count
);

    buf_state_t       r_state;
    buf_state_t       w_state_nxt;
    logic [SEL_W-1:0] r_buf_sel;
    logic [WIDTH-1:0] r_buf_data;
    logic [WIDTH-1:0] r_regs [NREG];
    logic [7:0]       r_count;
    logic [NREG-1:0]  w_we;
    logic             w_accept;
    logic             w_commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept while committing keeps the buffer FULL: the old entry drains, the new one replaces it.
    always_comb begin
        wr_ready    = (r_state == BUF_EMPTY) || !hold;
        w_accept    = wr_valid && wr_ready;
        w_commit    = (r_state == BUF_FULL) && !hold;
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = BUF_FULL;
        end else if (w_commit) begin
            w_state_nxt = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf_sel  <= '0;
            r_buf_data <= '0;
        end else if (w_accept) begin
            r_buf_sel  <= wr_sel;
            r_buf_data <= wr_data;
        end
    end

    dec3_8 u_dec (
        .i_en     (w_commit),
        .i_sel    (r_buf_sel),
        .o_onehot (w_we)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= r_buf_data;
                end
            end
            if (w_commit) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_out
`ifdef REGFILE_BYPASS_EN
        assign regs_flat[gi*WIDTH +: WIDTH] =
            ((r_state == BUF_FULL) && (r_buf_sel == SEL_W'(gi))) ? r_buf_data : r_regs[gi];
`else
        assign regs_flat[gi*WIDTH +: WIDTH] = r_regs[gi];
`endif
    end

    assign pend_valid = (r_state == BUF_FULL);
    assign wr_count   = r_count;

endmodule

// File: tb/tb_reg_write_demux8_16.sv
// Directed self-checking bench for reg_write_demux8_16 (either REGFILE_BYPASS_EN build).
module tb_reg_write_demux8_16;

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic [2:0]   wr_sel;
    logic [15:0]  wr_data;
    logic         wr_ready;
    logic         hold;
    logic [127:0] regs_flat;
    logic         pend_valid;
    logic [7:0]   wr_count;

    int unsigned  n_checks;
    int unsigned  n_fail;
    logic [127:0] exp_flat;

    reg_write_demux8_16 #(.WIDTH(16), .NREG(8), .SEL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .hold       (hold),
        .regs_flat  (regs_flat),
        .pend_valid (pend_valid),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] reg_of(input logic [127:0] f, input int unsigned n);
        return f[n*16 +: 16];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; hold = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (regs_flat !== 128'h0) begin n_fail++; $display("FAIL reset_regs got=%h exp=0", regs_flat); end
        n_checks++;
        if (wr_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", wr_count); end
        n_checks++;
        if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend got=%b exp=0", pend_valid); end
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
        exp_flat = '0;
    endtask

    task automatic test_single_write();
        wr_valid = 1'b1; wr_sel = 3'd5; wr_data = 16'hBEEF;
        tick();
        wr_valid = 1'b0;
        n_checks++;
        if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL single_pend got=%b exp=1", pend_valid); end
`ifdef REGFILE_BYPASS_EN
        n_checks++;
        if (reg_of(regs_flat, 5) !== 16'hBEEF) begin n_fail++; $display("FAIL single_bypass got=%h exp=beef", reg_of(regs_flat, 5)); end
`else
        n_checks++;
        if (reg_of(regs_flat, 5) !== 16'h0) begin n_fail++; $display("FAIL single_early got=%h exp=0", reg_of(regs_flat, 5)); end
`endif
        tick();
        exp_flat[5*16 +: 16] = 16'hBEEF;
        n_checks++;
        if (regs_flat !== exp_flat) begin n_fail++; $display("FAIL single_regs got=%h exp=%h", regs_flat, exp_flat); end
        n_checks++;
        if (wr_count !== 8'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", wr_count); end
        n_checks++;
        if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", pend_valid); end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 16'h1111;
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got=%b exp=1", wr_ready); end
        tick();
        wr_data = 16'h2222;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", wr_ready); end
        tick();
        n_checks++;
        if (reg_of(regs_flat, 2) !== 16'h1111) begin n_fail++; $display("FAIL b2b_first got=%h exp=1111", reg_of(regs_flat, 2)); end
        wr_sel = 3'd7; wr_data = 16'h7777;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got=%b exp=1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        tick();
        exp_flat[2*16 +: 16] = 16'h2222;
        exp_flat[7*16 +: 16] = 16'h7777;
        n_checks++;
        if (regs_flat !== exp_flat) begin n_fail++; $display("FAIL b2b_regs got=%h exp=%h", regs_flat, exp_flat); end
        // One earlier commit from the single-write test plus these three.
        n_checks++;
        if (wr_count !== 8'd4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", wr_count); end
    endtask

    task automatic test_hold();
        wr_valid = 1'b1; wr_sel = 3'd3; wr_data = 16'hA5A5;
        tick();
        hold = 1'b1; wr_sel = 3'd0; wr_data = 16'hFFFF;
        for (int unsigned c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready c=%0d got=%b exp=0", c, wr_ready); end
            n_checks++;
            if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL hold_pend c=%0d got=%b exp=1", c, pend_valid); end
`ifdef REGFILE_BYPASS_EN
            n_checks++;
            if (reg_of(regs_flat, 3) !== 16'hA5A5) begin n_fail++; $display("FAIL hold_bypass c=%0d got=%h exp=a5a5", c, reg_of(regs_flat, 3)); end
`else
            n_checks++;
            if (reg_of(regs_flat, 3) !== 16'h0) begin n_fail++; $display("FAIL hold_r3 c=%0d got=%h exp=0", c, reg_of(regs_flat, 3)); end
`endif
            n_checks++;
            if (wr_count !== 8'd4) begin n_fail++; $display("FAIL hold_count c=%0d got=%0d exp=4", c, wr_count); end
            tick();
        end
        wr_valid = 1'b0; hold = 1'b0;
        tick();
        exp_flat[3*16 +: 16] = 16'hA5A5;
        n_checks++;
        if (regs_flat !== exp_flat) begin n_fail++; $display("FAIL hold_release got=%h exp=%h", regs_flat, exp_flat); end
        n_checks++;
        if (wr_count !== 8'd5) begin n_fail++; $display("FAIL hold_count_rel got=%0d exp=5", wr_count); end
    endtask

    task automatic test_reset_discard();
        wr_valid = 1'b1; wr_sel = 3'd1; wr_data = 16'h0F0F;
        tick();
        wr_valid = 1'b0; hold = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; hold = 1'b0;
        #1;
        n_checks++;
        if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL discard_pend got=%b exp=0", pend_valid); end
        tick();
        tick();
        n_checks++;
        if (regs_flat !== 128'h0) begin n_fail++; $display("FAIL discard_regs got=%h exp=0", regs_flat); end
        n_checks++;
        if (wr_count !== 8'd0) begin n_fail++; $display("FAIL discard_count got=%0d exp=0", wr_count); end
        exp_flat = '0;
    endtask

    task automatic test_sweep_wrap();
        logic [2:0]  s;
        logic [15:0] d;
        for (int unsigned i = 0; i < 8; i++) begin
            s = 3'(i);
            d = 16'hC000 | 16'(i * 16'h0111);
            wr_valid = 1'b1; wr_sel = s; wr_data = d;
            tick();
            wr_valid = 1'b0;
            tick();
            exp_flat[i*16 +: 16] = d;
            n_checks++;
            if (regs_flat !== exp_flat) begin n_fail++; $display("FAIL sweep_%0d got=%h exp=%h", i, regs_flat, exp_flat); end
        end
        for (int unsigned k = 0; k < 248; k++) begin
            s = 3'(k);
            d = 16'h5000 + 16'(k);
            wr_valid = 1'b1; wr_sel = s; wr_data = d;
            exp_flat[(k % 8)*16 +: 16] = d;
            tick();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (wr_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got=%0d exp=255", wr_count); end
        tick();
        n_checks++;
        if (wr_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0 got=%0d exp=0", wr_count); end
        n_checks++;
        if (regs_flat !== exp_flat) begin n_fail++; $display("FAIL wrap_regs got=%h exp=%h", regs_flat, exp_flat); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_flat = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_hold();
        test_reset_discard();
        test_sweep_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
